dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Single-port arbiter for the vector data memory used by the writeback stage. It shares the memory between the pipeline writeback port, which has priority, and a host/loader port used for program data preload and result readback. A bounded-wait counter guarantees the host is never starved. Read data is returned one cycle after the grant, tagged to the requester that issued the access.

## Interface
Parameters:
- vecSize, 4: lanes per memory word
- registerSize, 8: bits per lane; also the address width
- MAX_WAIT, 4: consecutive denied host cycles before the host is forced in; legal range 1..255

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pipe_req  in  1  pipeline access request, valid this cycle
- pipe_we  in  1  1 = write, 0 = read
- pipe_addr  in  registerSize  word address
- pipe_wdata  in  vecSize*registerSize  write vector
- pipe_gnt  out  1  access accepted this cycle; when low with pipe_req high, the pipeline must stall
- pipe_rvalid  out  1  read data for the pipeline is valid on rdata
- host_req / host_we / host_addr / host_wdata  in  1 / 1 / registerSize / vecSize*registerSize  host access, same meanings as the pipe port
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  read data for the host is valid on rdata
- rdata  out  vecSize*registerSize  shared read return, driven from mem_rdata
- mem_we  out  1  memory write enable
- mem_addr  out  registerSize  memory address
- mem_wdata  out  vecSize*registerSize  memory write data
- mem_rdata  in  vecSize*registerSize  memory read data, registered inside the memory (1-cycle latency)
- host_lock  in  1  present only with DMEM_ARB_LOCK_EN

## Operation
- The state register has three states: NORMAL, FORCE_HOST, and LOCKED (LOCKED exists only with DMEM_ARB_LOCK_EN).
- Grants are combinational from the current state and the requests. At most one grant is high per cycle.
- NORMAL:
  - pipe_req wins. host_gnt is high only when pipe_req is low.
- FORCE_HOST:
  - host_gnt = host_req and pipe_gnt = 0, regardless of pipe_req.
  - The state returns to NORMAL on the next edge.
- Wait counter (registerSize bits):
  - Increments on each edge where host_req is high and host_gnt is low.
  - Clears on any edge where host_req is low or host_gnt is high.
  - When the counter reaches MAX_WAIT-1 in NORMAL with a denied host, the next state is FORCE_HOST.
  - The counter never exceeds MAX_WAIT-1.
- Memory mux:
  - The granted port drives mem_addr, mem_we and mem_wdata.
  - With no grant, mem_we = 0, and mem_addr and mem_wdata hold the pipe port values.
- Read return:
  - A 2-bit tag register captures {host_gnt & ~host_we, pipe_gnt & ~pipe_we} each edge.
  - pipe_rvalid and host_rvalid are the tag bits; rdata = mem_rdata.
  - Writes produce no rvalid.
- Requesters hold req, we, addr and wdata stable until granted. A host that drops host_req while waiting clears the counter.

## Timing
- Grant: same cycle as the request (0-cycle arbitration). The write commits at the edge ending the grant cycle.
- Read: rvalid and rdata are valid exactly one cycle after the grant cycle. Back-to-back reads are possible every cycle.
- Worst-case host wait: MAX_WAIT cycles of denial, then a grant in the following cycle.
- Reset values: state NORMAL, counter 0, tag 0. While reset is high, pipe_gnt = host_gnt = mem_we = 0 and pipe_rvalid = host_rvalid = 0 on the following cycle.
- Reset mid-operation: an outstanding read tag is dropped (no rvalid after reset), and an active lock is released.
- Read followed by a write of the same address in the next cycle: the read returns the old data.

## Configuration
- DMEM_ARB_LOCK_EN defined:
  - Adds the host_lock input and the LOCKED state.
  - A granted host access with host_lock = 1 moves the state to LOCKED on the edge.
  - In LOCKED, host_gnt = host_req and pipe_gnt = 0.
  - The state exits to NORMAL on the first edge with host_lock = 0, and the counter clears.
  - The lock is used for atomic multi-word preload.
- Not defined: the port is absent and the state never leaves NORMAL/FORCE_HOST; behaviour is otherwise identical.

## Test plan
- Pipe write 0xAA at addr 5, then pipe read addr 5 -> pipe_gnt high both cycles; next cycle pipe_rvalid = 1, host_rvalid = 0, rdata = {0xAA,0xAA,0xAA,0xAA}.
- pipe_req and host_req continuously high, MAX_WAIT=4 -> host denied 4 cycles, host_gnt high in cycle 5 with pipe_gnt low, then pipe regains the grant; the pattern repeats every 5 cycles.
- Host read addr 9 while pipe is idle -> host_gnt in the same cycle, host_rvalid next cycle, pipe_rvalid stays 0.
- Host waits 3 cycles, drops its request for 1 cycle, then re-requests -> the counter restarts, and the forced grant comes only after 4 further denials.
- Pipe read granted, then reset asserted in the next cycle -> both rvalids 0, both grants 0 during reset, state NORMAL after release.
- With DMEM_ARB_LOCK_EN: host write with host_lock=1, then 3 host writes with pipe_req high -> pipe_gnt stays 0 throughout; lock dropped -> pipe granted on the next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one single-port vector data memory between the
// pipeline writeback port (priority) and a host/loader port. A bounded-wait
// counter forces a host grant after MAX_WAIT consecutive denials so the host
// is never starved. Read data returns one cycle after the grant, tagged to
// the port that issued it.
//
// Optional feature: define DMEM_ARB_LOCK_EN to add the host_lock input and
// the LOCKED state (host keeps the memory for atomic multi-word preload).
module dmem_port_arbiter #(
  parameter int unsigned vecSize      = 4,
  parameter int unsigned registerSize = 8,
  parameter int unsigned MAX_WAIT     = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  // Pipeline writeback port
  input  logic                             pipe_req,
  input  logic                             pipe_we,
  input  logic [registerSize-1:0]          pipe_addr,
  input  logic [vecSize*registerSize-1:0]  pipe_wdata,
  output logic                             pipe_gnt,
  output logic                             pipe_rvalid,
  // Host / loader port
  input  logic                             host_req,
  input  logic                             host_we,
  input  logic [registerSize-1:0]          host_addr,
  input  logic [vecSize*registerSize-1:0]  host_wdata,
  output logic                             host_gnt,
  output logic                             host_rvalid,
`ifdef DMEM_ARB_LOCK_EN
  input  logic                             host_lock,
`endif
  // Shared read return
  output logic [vecSize*registerSize-1:0]  rdata,
  // Memory side
  output logic                             mem_we,
  output logic [registerSize-1:0]          mem_addr,
  output logic [vecSize*registerSize-1:0]  mem_wdata,
  input  logic [vecSize*registerSize-1:0]  mem_rdata
);

  localparam logic [registerSize-1:0] WaitLast = registerSize'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    StNormal    = 2'd0,
    StForceHost = 2'd1,
    StLocked    = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [registerSize-1:0] wait_q, wait_d;
  // {host read outstanding, pipe read outstanding}
  logic [1:0]              tag_q, tag_d;

  logic host_denied;

  // Same-cycle grant decode; nothing is granted while reset is held
  always_comb begin
    pipe_gnt = 1'b0;
    host_gnt = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StNormal: begin
          pipe_gnt = pipe_req;
          host_gnt = host_req & ~pipe_req;
        end
        StForceHost, StLocked: begin
          host_gnt = host_req;
        end
        default: begin
          pipe_gnt = 1'b0;
          host_gnt = 1'b0;
        end
      endcase
    end
  end

  assign host_denied = host_req & ~host_gnt;

  // Next state, bounded-wait counter and read tag
  always_comb begin
    state_d = state_q;
    // Saturate at MAX_WAIT-1: the forced grant follows that denial anyway
    if (host_denied) begin
      wait_d = (wait_q == WaitLast) ? wait_q : wait_q + 1'b1;
    end else begin
      wait_d = '0;
    end
    tag_d = {host_gnt & ~host_we, pipe_gnt & ~pipe_we};

    case (state_q)
      StNormal: begin
        if (host_denied && (wait_q == WaitLast)) state_d = StForceHost;
      end
      StForceHost: begin
        state_d = StNormal;
      end
`ifdef DMEM_ARB_LOCK_EN
      StLocked: begin
        if (!host_lock) begin
          state_d = StNormal;
          wait_d  = '0;
        end
      end
`endif
      default: begin
        state_d = StNormal;
      end
    endcase

`ifdef DMEM_ARB_LOCK_EN
    // A granted host access that asks for the lock keeps the memory
    if (host_gnt && host_lock) state_d = StLocked;
`endif
  end

  // State, counter and tag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StNormal;
      wait_q  <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      tag_q   <= tag_d;
    end
  end

  // Memory mux: granted port drives; idle defaults to pipe values, no write
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = pipe_addr;
    mem_wdata = pipe_wdata;
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (pipe_gnt) begin
      mem_we = pipe_we;
    end
  end

  // Outstanding reads are dropped when reset arrives
  assign pipe_rvalid = tag_q[0] & ~reset;
  assign host_rvalid = tag_q[1] & ~reset;
  assign rdata       = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: the driver pushes the expected
// grants for each cycle and the expected read returns; a negedge monitor
// pops and compares. A behavioural 1-cycle-latency memory sits on mem_*.
module tb_dmem_port_arbiter;

  localparam int unsigned VS = 4;
  localparam int unsigned RS = 8;
  localparam int unsigned DW = VS * RS;

  logic          clk = 1'b1;
  logic          reset;
  logic          pipe_req, pipe_we, host_req, host_we, host_lock;
  logic [RS-1:0] pipe_addr, host_addr, mem_addr;
  logic [DW-1:0] pipe_wdata, host_wdata, rdata, mem_wdata, mem_rdata;
  logic          pipe_gnt, pipe_rvalid, host_gnt, host_rvalid, mem_we;

  dmem_port_arbiter #(
    .vecSize     (VS),
    .registerSize(RS),
    .MAX_WAIT    (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_req   (pipe_req),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_gnt   (pipe_gnt),
    .pipe_rvalid(pipe_rvalid),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_rvalid(host_rvalid),
`ifdef DMEM_ARB_LOCK_EN
    .host_lock  (host_lock),
`endif
    .rdata      (rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural memory with registered read
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    bit pg;
    bit hg;
    bit we;
  } gnt_t;

  typedef struct {
    int          due;
    bit          host;
    logic [DW-1:0] data;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];
  gnt_t ge;
  rd_t  re;
  logic [DW-1:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  localparam logic [DW-1:0] A = 32'hAAAA_AAAA;
  localparam logic [DW-1:0] H = 32'h0102_0304;
  localparam logic [DW-1:0] F = 32'h5555_5555;
  localparam logic [DW-1:0] Z = 32'h0;

  // Monitor: grants every driven cycle, read returns when due
  always @(negedge clk) begin
    if (gq.size() > 0) begin
      ge = gq.pop_front();
      checks++;
      if ({pipe_gnt, host_gnt, mem_we} !== {ge.pg, ge.hg, ge.we}) begin
        errors++;
        $display("FAIL grant cyc=%0d lock=%b: got pg=%b hg=%b we=%b, want pg=%b hg=%b we=%b",
                 cyc, host_lock, pipe_gnt, host_gnt, mem_we, ge.pg, ge.hg, ge.we);
      end
    end
    if (rq.size() > 0 && rq[0].due == cyc) begin
      re = rq.pop_front();
      checks++;
      if (pipe_rvalid !== !re.host || host_rvalid !== re.host || rdata !== re.data) begin
        errors++;
        $display("FAIL rdata cyc=%0d: got prv=%b hrv=%b rdata=%h, want prv=%b hrv=%b rdata=%h",
                 cyc, pipe_rvalid, host_rvalid, rdata, !re.host, re.host, re.data);
      end
    end else if (pipe_rvalid !== 1'b0 || host_rvalid !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL spurious_rvalid cyc=%0d: got prv=%b hrv=%b, want 0 0",
               cyc, pipe_rvalid, host_rvalid);
    end
  end

  // One cycle of stimulus plus hand-computed grant expectation
  task automatic drive(input bit rst, input bit pr, input bit pwe, input logic [RS-1:0] pa,
                       input logic [DW-1:0] pwd, input bit hr, input bit hwe,
                       input logic [RS-1:0] ha, input logic [DW-1:0] hwd, input bit lk,
                       input bit epg, input bit ehg);
    gnt_t g;
    rd_t  r;
    reset      = rst;
    pipe_req   = pr;
    pipe_we    = pwe;
    pipe_addr  = pa;
    pipe_wdata = pwd;
    host_req   = hr;
    host_we    = hwe;
    host_addr  = ha;
    host_wdata = hwd;
    host_lock  = lk;
    g.pg = epg;
    g.hg = ehg;
    g.we = (epg & pwe) | (ehg & hwe);
    gq.push_back(g);
    if (epg && !pwe) begin
      r.due = cyc + 1; r.host = 1'b0; r.data = ref_mem[pa];
      rq.push_back(r);
    end
    if (ehg && !hwe) begin
      r.due = cyc + 1; r.host = 1'b1; r.data = ref_mem[ha];
      rq.push_back(r);
    end
    if (epg && pwe) ref_mem[pa] = pwd;
    if (ehg && hwe) ref_mem[ha] = hwd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, Z, 0, 0, 0, Z, 0, 0, 0);
  endtask

  // Both ports reading continuously; bit pattern gives pipe/host grant per cycle
  task automatic both_read(input int n, input bit ehg_last);
    for (int i = 0; i < n; i++) begin
      if (ehg_last && i == n - 1) drive(0, 1, 0, 5, Z, 1, 0, 9, Z, 0, 0, 1);
      else                        drive(0, 1, 0, 5, Z, 1, 0, 9, Z, 0, 1, 0);
    end
  endtask

  initial begin
    // Reset with both requesting writes: no grants, no write enable
    drive(1, 1, 1, 5, A, 1, 1, 9, H, 0, 0, 0);
    drive(1, 1, 1, 5, A, 1, 1, 9, H, 0, 0, 0);

    // Pipe write then read of addr 5
    drive(0, 1, 1, 5, A, 0, 0, 0, Z, 0, 1, 0);
    drive(0, 1, 0, 5, Z, 0, 0, 0, Z, 0, 1, 0);
    idle(1);

    // Host write / read of addr 9 with pipe idle
    drive(0, 0, 0, 0, Z, 1, 1, 9, H, 0, 0, 1);
    drive(0, 0, 0, 0, Z, 1, 0, 9, Z, 0, 0, 1);
    idle(1);

    // Read then write same address: read returns old data
    drive(0, 1, 0, 5, Z, 0, 0, 0, Z, 0, 1, 0);
    drive(0, 1, 1, 5, F, 0, 0, 0, Z, 0, 1, 0);
    drive(0, 1, 0, 5, Z, 0, 0, 0, Z, 0, 1, 0);
    idle(1);

    // Continuous contention: 4 pipe grants then 1 host grant, twice
    both_read(5, 1);
    both_read(5, 1);
    drive(0, 1, 0, 5, Z, 0, 0, 0, Z, 0, 1, 0);

    // Host waits 3, drops for 1, then needs 4 further denials
    both_read(3, 0);
    drive(0, 1, 0, 5, Z, 0, 0, 0, Z, 0, 1, 0);
    both_read(5, 1);
    idle(1);

    // Reach the forcing point, then reset right after a pipe read grant
    both_read(4, 0);
    void'(rq.pop_back());
    drive(1, 1, 0, 5, Z, 1, 0, 9, Z, 0, 0, 0);
    both_read(5, 1);
    idle(1);

`ifdef DMEM_ARB_LOCK_EN
    // Locked multi-word host preload holds off the pipe
    drive(0, 0, 0, 0, Z, 1, 1, 20, H, 1, 0, 1);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 5, Z, 1, 1, RS'(21 + i), F, 1, 0, 1);
    drive(0, 1, 0, 5, Z, 0, 0, 0, Z, 0, 0, 0);
    drive(0, 1, 0, 5, Z, 0, 0, 0, Z, 0, 1, 0);
    drive(0, 0, 0, 0, Z, 1, 0, 22, Z, 0, 0, 1);
    idle(1);
`endif

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
